alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 21 ++
 rtl/alu_arbiter_alu.sv | 28 ++
 rtl/alu_arbiter.sv | 80 ++++++++
 3 files changed

// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared width, ALU op codes, FSM encoding and op-class helpers.
package alu_arbiter_pkg;
  localparam int XLEN = 32;
  localparam logic [3:0] ALU_OP_ADD  = 4'h0;
  localparam logic [3:0] ALU_OP_SUB  = 4'h1;
  localparam logic [3:0] ALU_OP_SLL  = 4'h2;
  localparam logic [3:0] ALU_OP_SLT  = 4'h3;
  localparam logic [3:0] ALU_OP_SLTU = 4'h4;
  localparam logic [3:0] ALU_OP_XOR  = 4'h5;
  localparam logic [3:0] ALU_OP_SRL  = 4'h6;
  localparam logic [3:0] ALU_OP_SRA  = 4'h7;
  localparam logic [3:0] ALU_OP_OR   = 4'h8;
  localparam logic [3:0] ALU_OP_AND  = 4'h9;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_RESP = 2'd2} state_e;
  function automatic logic is_shift(input logic [3:0] op);
    return op == ALU_OP_SLL || op == ALU_OP_SRL || op == ALU_OP_SRA;
  endfunction
  function automatic logic is_cmp(input logic [3:0] op);
    return op == ALU_OP_SLT || op == ALU_OP_SLTU;
  endfunction
endpackage

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu: combinational ALU; op codes outside the defined set yield 0.
module alu_arbiter_alu #(
  parameter int W = 32
) (
  input  logic [3:0]   op_in,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic [W-1:0] y_out
);
  import alu_arbiter_pkg::*;
  logic signed [W-1:0] sra;
  logic lt, ltu;
  always_comb begin
    sra = $signed(a_in) >>> b_in;
    lt  = $signed(a_in) < $signed(b_in);
    ltu = a_in < b_in;
    y_out = op_in == ALU_OP_ADD  ? a_in + b_in :
            op_in == ALU_OP_SUB  ? a_in - b_in :
            op_in == ALU_OP_SLL  ? a_in << b_in :
            op_in == ALU_OP_SLT  ? W'(lt) :
            op_in == ALU_OP_SLTU ? W'(ltu) :
            op_in == ALU_OP_XOR  ? a_in ^ b_in :
            op_in == ALU_OP_SRL  ? a_in >> b_in :
            op_in == ALU_OP_SRA  ? sra :
            op_in == ALU_OP_OR   ? a_in | b_in :
            op_in == ALU_OP_AND  ? a_in & b_in : '0;
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one ALU through a round-robin IDLE/EXEC/RESP FSM.
module alu_arbiter #(
  parameter int   XLEN       = alu_arbiter_pkg::XLEN,
  parameter logic FIRST_PRIO = 1'b0
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            flush_in,
  input  logic            req0_valid_in,
  output logic            req0_ready_out,
  input  logic [3:0]      req0_op_in,
  input  logic [XLEN-1:0] req0_a_in,
  input  logic [XLEN-1:0] req0_b_in,
  input  logic            req1_valid_in,
  output logic            req1_ready_out,
  input  logic [3:0]      req1_op_in,
  input  logic [XLEN-1:0] req1_a_in,
  input  logic [XLEN-1:0] req1_b_in,
  output logic            rsp0_valid_out,
  input  logic            rsp0_ready_in,
  output logic [XLEN-1:0] rsp0_result_out,
  output logic            rsp1_valid_out,
  input  logic            rsp1_ready_in,
  output logic [XLEN-1:0] rsp1_result_out,
  output logic            busy_out
);
  import alu_arbiter_pkg::*;
  state_e state_q, state_d;
  logic prio_q, prio_d, gnt_q, gnt_d, gnt_sel, accept, rsp_ready;
  logic [3:0] op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, res_q, res_d, b_alu, y;
  alu_arbiter_alu #(.W(XLEN)) u_alu (.op_in(op_q), .a_in(a_q), .b_in(b_alu), .y_out(y));
  // Reset gates acceptance so ready stays low while rst_n_in is asserted.
  always_comb begin
    gnt_sel   = (req0_valid_in && req1_valid_in) ? prio_q : req1_valid_in;
    accept    = rst_n_in && state_q == ST_IDLE && (req0_valid_in || req1_valid_in) && !flush_in;
    rsp_ready = gnt_q ? rsp1_ready_in : rsp0_ready_in;
    state_d   = flush_in ? ST_IDLE :
                state_q == ST_IDLE ? (accept ? ST_EXEC : ST_IDLE) :
                state_q == ST_EXEC ? ST_RESP :
                rsp_ready ? ST_IDLE : ST_RESP;
  end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) state_q <= ST_IDLE;
    else state_q <= state_d;
  always_comb begin
    prio_d = accept ? ~gnt_sel : prio_q;
    gnt_d  = accept ? gnt_sel : gnt_q;
    op_d   = accept ? (gnt_sel ? req1_op_in : req0_op_in) : op_q;
    a_d    = accept ? (gnt_sel ? req1_a_in : req0_a_in) : a_q;
    b_d    = accept ? (gnt_sel ? req1_b_in : req0_b_in) : b_q;
    b_alu  = is_shift(op_q) ? {{(XLEN-5){1'b0}}, b_q[4:0]} : b_q;
    res_d  = (state_q == ST_EXEC && !flush_in) ? (is_cmp(op_q) ? {{(XLEN-1){1'b0}}, y[0]} : y) : res_q;
  end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      prio_q <= FIRST_PRIO;
      gnt_q  <= 1'b0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
    end else begin
      prio_q <= prio_d;
      gnt_q  <= gnt_d;
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      res_q  <= res_d;
    end
  always_comb begin
    req0_ready_out  = accept && !gnt_sel;
    req1_ready_out  = accept && gnt_sel;
    rsp0_valid_out  = state_q == ST_RESP && !gnt_q;
    rsp1_valid_out  = state_q == ST_RESP && gnt_q;
    rsp0_result_out = state_q == ST_RESP ? res_q : '0;
    rsp1_result_out = state_q == ST_RESP ? res_q : '0;
    busy_out        = state_q != ST_IDLE;
  end
endmodule
